// File: rtl/ccip_c1_wr_arb_if.sv
// ccip_c1_wr_arb_if: bundles the requester-side beat handshake and the
// CCI-P c1 Tx-side outputs of the c1 write arbiter.
// The arbiter connects through the slave modport. A requester-side model
// or testbench connects through the master modport.
interface ccip_c1_wr_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int HDR_W   = 80,
    parameter int DATA_W  = 512
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*HDR_W-1:0]  req_hdr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      c1_alm_full;
    logic                      tx_valid;
    logic [HDR_W-1:0]          tx_hdr;
    logic [DATA_W-1:0]         tx_data;
    logic [2:0]                grant_owner;

    modport slave (
        input  req_valid, req_last, req_hdr, req_data, c1_alm_full,
        output req_ready, tx_valid, tx_hdr, tx_data, grant_owner
    );

    modport master (
        output req_valid, req_last, req_hdr, req_data, c1_alm_full,
        input  req_ready, tx_valid, tx_hdr, tx_data, grant_owner
    );
endinterface

// File: rtl/ccip_c1_wr_arb.sv
// ccip_c1_wr_arb: round-robin arbiter that shares the CCI-P c1 (memory
// write) Tx channel among NUM_REQ requesters.
// - A multi-beat packet locks the grant until its last beat.
// - c1TxAlmFull stalls all requesters.
// - tx_* outputs are registered and have exactly one cycle of latency.
// Optional feature: define CCIP_C1_WR_ARB_STATS_EN to add per-requester
// packet counters (stat_sel/stat_cnt) and an almost-full stall counter
// (stall_cnt).
module ccip_c1_wr_arb #(
    parameter int NUM_REQ = 4,
    parameter int HDR_W   = 80,
    parameter int DATA_W  = 512
) (
    input  logic               clk,
    input  logic               reset,
    ccip_c1_wr_arb_if.slave    bus
`ifdef CCIP_C1_WR_ARB_STATS_EN
    ,
    input  logic [2:0]         stat_sel,
    output logic [31:0]        stat_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // (base + k) mod NUM_REQ, where k < NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Next requester after idx, wrapping NUM_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] ready;
    logic               accept;
    logic               sel_last;
    logic [HDR_W-1:0]   sel_hdr;
    logic [DATA_W-1:0]  sel_data;
    logic               tx_valid_q;
    logic [HDR_W-1:0]   tx_hdr_q;
    logic [DATA_W-1:0]  tx_data_q;

    // Round-robin search: first valid requester starting at the rr pointer.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && bus.req_valid[rr_add(rr_q, k)]) begin
                win_vld = 1'b1;
                win_idx = rr_add(rr_q, k);
            end
        end
    end

    // Grant selection. A locked owner keeps ready even while its valid is low.
    always_comb begin
        ready = '0;
        if (state_q == ST_LOCKED) begin
            sel_idx        = owner_q;
            ready[owner_q] = !bus.c1_alm_full;
        end else begin
            sel_idx        = win_idx;
            ready[win_idx] = win_vld && !bus.c1_alm_full;
        end
        accept   = |(ready & bus.req_valid);
        sel_last = bus.req_last[sel_idx];
    end

    // Header/data mux for the selected requester.
    always_comb begin
        sel_hdr  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_hdr  = bus.req_hdr[i*HDR_W +: HDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Lock/unlock and rr pointer advance on accepted beats.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        if (accept) begin
            owner_d = sel_idx;
            if (sel_last) begin
                state_d = ST_IDLE;
                rr_d    = rr_next(sel_idx);
            end else begin
                state_d = ST_LOCKED;
            end
        end
    end

    // Arbiter control state. Reset drops any lock in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    // Registered c1 Tx outputs. Header and data hold between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q <= 1'b0;
            tx_hdr_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            tx_valid_q <= accept;
            if (accept) begin
                tx_hdr_q  <= sel_hdr;
                tx_data_q <= sel_data;
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_hdr      = tx_hdr_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_owner = 3'(owner_q);

`ifdef CCIP_C1_WR_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_REQ];
    logic [31:0] stat_pick;
    logic [31:0] stat_cnt_q;
    logic [31:0] stall_cnt_q;

    // Per-requester completed-packet counters. They wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) pkt_cnt_q[i] <= '0;
        end else if (accept && sel_last) begin
            pkt_cnt_q[sel_idx] <= pkt_cnt_q[sel_idx] + 32'd1;
        end
    end

    // Select the counter to report. Out-of-range selects read as zero.
    always_comb begin
        stat_pick = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == stat_sel) stat_pick = pkt_cnt_q[i];
        end
    end

    // Registered counter readout, and count of cycles stalled by almost-full with work pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            stat_cnt_q <= stat_pick;
            if (bus.c1_alm_full && |bus.req_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stat_cnt  = stat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ccip_c1_wr_arb.sv
// Directed testbench for ccip_c1_wr_arb (4 requesters, 80-bit header, 512-bit data).
module tb_ccip_c1_wr_arb;
    localparam int NR = 4;
    localparam int HW = 80;
    localparam int DW = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ccip_c1_wr_arb_if #(.NUM_REQ(NR), .HDR_W(HW), .DATA_W(DW)) bus ();

`ifdef CCIP_C1_WR_ARB_STATS_EN
    logic [2:0]  stat_sel = 3'd0;
    logic [31:0] stat_cnt;
    logic [31:0] stall_cnt;
`endif

    ccip_c1_wr_arb #(.NUM_REQ(NR), .HDR_W(HW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef CCIP_C1_WR_ARB_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [HW-1:0] mk_hdr(input int i, input int b);
        return HW'(32'hA000_0000 + 32'(i * 256 + b));
    endfunction

    function automatic logic [DW-1:0] mk_data(input int i, input int b);
        return DW'(32'hD000_0000 + 32'(i * 256 + b));
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input int b);
        bus.req_valid[i]           = v;
        bus.req_last[i]            = l;
        bus.req_hdr[i*HW +: HW]    = mk_hdr(i, b);
        bus.req_data[i*DW +: DW]   = mk_data(i, b);
    endtask

    task automatic check_tx(input string tag, input int i, input int b);
        check({tag, "_vld"},   512'(bus.tx_valid), 512'(1'b1));
        check({tag, "_hdr"},   512'(bus.tx_hdr), 512'(mk_hdr(i, b)));
        check({tag, "_data"},  512'(bus.tx_data), 512'(mk_data(i, b)));
        check({tag, "_owner"}, 512'(bus.grant_owner), 512'(3'(i)));
    endtask

    task automatic check_rdy(input string tag, input logic [NR-1:0] exp);
        check(tag, 512'(bus.req_ready), 512'(exp));
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_last    = '0;
        bus.req_hdr     = '0;
        bus.req_data    = '0;
        bus.c1_alm_full = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_vld",   512'(bus.tx_valid), 512'(1'b0));
        check("rst_hdr",   512'(bus.tx_hdr), 512'(0));
        check("rst_data",  512'(bus.tx_data), 512'(0));
        check("rst_owner", 512'(bus.grant_owner), 512'(0));
        check_rdy("rst_rdy", 4'b0000);
        reset = 1'b0;

        // All four requesters with single-line writes: grants 0,1,2,3,0
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 0);
        settle();
        check_rdy("rr_rdy0", 4'b0001);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_tx("rr_tx", c % 4, 0);
            check_rdy("rr_rdy", 4'(1 << ((c + 1) % 4)));
            if (c == 4) bus.req_valid = '0;
        end
        tick();
        check("rr_idle_vld", 512'(bus.tx_valid), 512'(1'b0));
        check("rr_hold_hdr", 512'(bus.tx_hdr), 512'(mk_hdr(0, 0)));

        // Four-beat packet from requester 1 locks out requester 2 (rr=1)
        set_req(1, 1'b1, 1'b0, 0);
        set_req(2, 1'b1, 1'b1, 0);
        settle();
        check_rdy("pk_rdy0", 4'b0010);
        for (int b = 0; b < 4; b++) begin
            tick();
            check_tx("pk_tx", 1, b);
            if (b < 3) begin
                set_req(1, 1'b1, (b + 1 == 3), b + 1);
                settle();
                check_rdy("pk_lock_rdy", 4'b0010);
            end else begin
                set_req(1, 1'b0, 1'b0, 0);
                settle();
                check_rdy("pk_rel_rdy", 4'b0100);
            end
        end
        tick();
        check_tx("pk_r2", 2, 0);
        set_req(2, 1'b0, 1'b0, 0);
        tick();
        check("pk_end_vld", 512'(bus.tx_valid), 512'(1'b0));

        // Almost-full stall for 3 cycles inside requester 0's 2-beat packet (rr=3)
        set_req(0, 1'b1, 1'b0, 0);
        settle();
        check_rdy("af_rdy0", 4'b0001);
        tick();
        check_tx("af_b0", 0, 0);
        set_req(0, 1'b1, 1'b1, 1);
        set_req(2, 1'b1, 1'b1, 0);
        bus.c1_alm_full = 1'b1;
        settle();
        check_rdy("af_stall_rdy", 4'b0000);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("af_stall_vld", 512'(bus.tx_valid), 512'(1'b0));
            check_rdy("af_stall_rdy", 4'b0000);
        end
        bus.c1_alm_full = 1'b0;
        settle();
        check_rdy("af_lock_rdy", 4'b0001);
        tick();
        check_tx("af_b1", 0, 1);
        set_req(0, 1'b0, 1'b0, 0);
        settle();
        check_rdy("af_after_rdy", 4'b0100);
        tick();
        check_tx("af_r2", 2, 0);
        set_req(2, 1'b0, 1'b0, 0);
        tick();

        // rr=3 with requesters 3 and 0: grant 3, then wrap to 0, leaving rr=1
        set_req(3, 1'b1, 1'b1, 0);
        set_req(0, 1'b1, 1'b1, 0);
        settle();
        check_rdy("wr_rdy3", 4'b1000);
        tick();
        check_tx("wr_tx3", 3, 0);
        check_rdy("wr_rdy0", 4'b0001);
        tick();
        check_tx("wr_tx0", 0, 0);
        set_req(1, 1'b1, 1'b1, 0);
        set_req(2, 1'b1, 1'b1, 0);
        settle();
        check_rdy("wr_rr1", 4'b0010);

        // A single active requester is re-granted every cycle
        set_req(0, 1'b0, 1'b1, 0);
        set_req(2, 1'b0, 1'b1, 0);
        set_req(3, 1'b0, 1'b1, 0);
        for (int r = 0; r < 3; r++) begin
            tick();
            check_tx("solo_tx", 1, 0);
            check_rdy("solo_rdy", 4'b0010);
        end
        set_req(1, 1'b0, 1'b0, 0);
        tick();

        // Almost-full rising together with a request: nothing accepted
        set_req(1, 1'b1, 1'b1, 0);
        bus.c1_alm_full = 1'b1;
        settle();
        check_rdy("afr_rdy", 4'b0000);
        tick();
        check("afr_vld", 512'(bus.tx_valid), 512'(1'b0));
        bus.c1_alm_full = 1'b0;
        set_req(1, 1'b0, 1'b0, 0);
        tick();

        // Reset while locked to requester 2 (rr=2)
        set_req(2, 1'b1, 1'b0, 0);
        settle();
        check_rdy("rl_rdy2", 4'b0100);
        tick();
        check_tx("rl_tx2", 2, 0);
        reset = 1'b1;
        tick();
        check("rl_vld",   512'(bus.tx_valid), 512'(1'b0));
        check("rl_owner", 512'(bus.grant_owner), 512'(0));
        check("rl_hdr",   512'(bus.tx_hdr), 512'(0));
        reset = 1'b0;
        set_req(2, 1'b0, 1'b0, 0);
        set_req(0, 1'b1, 1'b1, 0);
        settle();
        check_rdy("rl_idle_rdy", 4'b0001);
        tick();
        check_tx("rl_tx0", 0, 0);
        set_req(0, 1'b0, 1'b0, 0);
        tick();

`ifdef CCIP_C1_WR_ARB_STATS_EN
        // Packet and stall counters
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stat_sel = 3'd1;
        set_req(1, 1'b1, 1'b1, 0);
        for (int p = 0; p < 5; p++) tick();
        set_req(1, 1'b0, 1'b0, 0);
        tick();
        check("st_pkt_cnt", 512'(stat_cnt), 512'(32'd5));
        check("st_stall0", 512'(stall_cnt), 512'(32'd0));
        set_req(2, 1'b1, 1'b1, 0);
        bus.c1_alm_full = 1'b1;
        for (int s = 0; s < 3; s++) tick();
        check("st_stall3", 512'(stall_cnt), 512'(32'd3));
        bus.c1_alm_full = 1'b0;
        set_req(2, 1'b0, 1'b0, 0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
